// File: rtl/iomem_fifo_periph.sv
// rtl/iomem_fifo_periph.sv - iomem-bus mapped 32-bit FIFO with status flags and threshold interrupt
module iomem_fifo_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]    state_q,  state_d;
    logic          ready_q,  ready_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic          irq_q,    irq_d;
    logic          enable_q, enable_d;
    logic          irq_en_q, irq_en_d;
    logic [8:0]    thresh_q, thresh_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push;
    logic          sel;
    logic          is_write;
    logic          full;
    logic          empty;
    logic [8:0]    count_ext;
    logic [31:0]   status;
    logic          unused_addr;

    // Storage is deliberately left without reset; only pointers/count define validity.
    logic [31:0]   mem_q [DEPTH];

    assign sel         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign is_write    = (iomem_wstrb != 4'b0000);
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign count_ext   = 9'(count_q);
    assign status      = {15'b0, count_ext, 4'b0, udf_q, ovf_q, full, empty};
    assign unused_addr = ^iomem_addr[1:0];

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq_out     = irq_q;

    // Responder FSM and register/FIFO side effects; everything commits on the edge leaving IDLE.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        rdata_d  = 32'b0;
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    state_d = S_ACK;
                    ready_d = 1'b1;
                    case (iomem_addr[7:2])
                        6'h00: begin
                            if (is_write) begin
                                if (iomem_wstrb[0]) begin
                                    enable_d = iomem_wdata[0];
                                    irq_en_d = iomem_wdata[1];
                                    if (iomem_wdata[2]) begin
                                        wr_ptr_d = '0;
                                        rd_ptr_d = '0;
                                        count_d  = '0;
                                        ovf_d    = 1'b0;
                                        udf_d    = 1'b0;
                                    end
                                end
                            end else begin
                                rdata_d = {30'b0, irq_en_q, enable_q};
                            end
                        end
                        6'h01: begin
                            if (!is_write) begin
                                rdata_d = status;
                            end
                        end
                        6'h02: begin
                            if (is_write) begin
                                if (enable_q) begin
                                    if (full) begin
                                        ovf_d = 1'b1;
                                    end else begin
                                        push     = 1'b1;
                                        wr_ptr_d = wr_ptr_q + PW'(1);
                                        count_d  = count_q + CW'(1);
                                    end
                                end
                            end else if (!empty) begin
                                rdata_d  = mem_q[rd_ptr_q];
                                rd_ptr_d = rd_ptr_q + PW'(1);
                                count_d  = count_q - CW'(1);
                            end else begin
                                udf_d = 1'b1;
                            end
                        end
                        6'h03: begin
                            if (is_write) begin
                                if (iomem_wstrb[0]) begin
                                    thresh_d[7:0] = iomem_wdata[7:0];
                                end
                                if (iomem_wstrb[1]) begin
                                    thresh_d[8] = iomem_wdata[8];
                                end
                            end else begin
                                rdata_d = {23'b0, thresh_q};
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Interrupt is registered from current state, so it follows a count change by one cycle.
    always_comb begin
        irq_d = irq_en_q && (((thresh_q != 9'd0) && (count_ext >= thresh_q)) || ovf_q);
    end

    // Control/status state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= 32'b0;
            irq_q    <= 1'b0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= 9'd0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO word storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= iomem_wdata;
        end
    end
endmodule

// File: doc/iomem_fifo_periph.md
IOMEM_FIFO_PERIPH -- requirements
Module: iomem_fifo_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, meaning the 256-byte register window base; bits [7:0] are zero.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the FIFO depth in 32-bit words; it is a power of 2 between 2 and 256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port iomem_valid, input, 1 bit: the initiator's request strobe.
REQ-006 SHALL have port iomem_ready, output, 1 bit: the responder's completion strobe.
REQ-007 SHALL have port iomem_wstrb, input, 4 bits: byte write strobes; 0 means a read.
REQ-008 SHALL have port iomem_addr, input, 32 bits: byte address.
REQ-009 SHALL have port iomem_wdata, input, 32 bits: write data.
REQ-010 SHALL have port iomem_rdata, output, 32 bits: read data, valid while iomem_ready=1.
REQ-011 SHALL have port irq_out, output, 1 bit: level interrupt.

Function
REQ-012 SHALL select an access when iomem_valid=1 and iomem_addr[31:8]==BASE_ADDR[31:8]; it SHALL never drive iomem_ready for an unselected address.
REQ-013 SHALL use a 2-state responder FSM, IDLE and ACK.
REQ-014 In IDLE, a selected access SHALL commit its side effects on the next edge and move to ACK.
REQ-015 In ACK, iomem_ready SHALL be 1 for exactly one cycle, iomem_valid SHALL be ignored, and the FSM SHALL return to IDLE.
REQ-016 Access latency SHALL be 1 wait cycle (iomem_ready is high in the 2nd cycle of iomem_valid).
REQ-017 iomem_ready SHALL be registered; iomem_rdata SHALL be registered, and SHALL be 0 whenever iomem_ready=0.
REQ-018 Offset 0x00 CTRL (RW) SHALL be: bit0 enable, bit1 irq_en; bit2 clear reads as 0 and a write of 1 empties the FIFO and clears the sticky flags; only wstrb[0] updates CTRL.
REQ-019 Offset 0x04 STATUS (RO) SHALL be: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky), bits[16:8] count, others 0.
REQ-020 Offset 0x08 DATA, on write with any nonzero wstrb: if enable=1 and not full, SHALL push the full 32-bit iomem_wdata.
REQ-021 Offset 0x08 DATA, on write: if full, SHALL drop the data and set overflow; if enable=0, SHALL ignore the write.
REQ-022 Offset 0x08 DATA, on read: if not empty, SHALL return the head word and pop it; if empty, SHALL return 0 and set underflow (regardless of enable).
REQ-023 Offset 0x0C THRESH (RW) SHALL be bits[8:0]; only wstrb[1:0] lanes update it.
REQ-024 Unmapped offsets SHALL acknowledge normally, read 0 and ignore writes.
REQ-025 FIFO pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-026 irq_out SHALL be registered, and SHALL equal irq_en AND ((THRESH!=0 AND count>=THRESH) OR overflow).
REQ-027 When CTRL clear and other CTRL bits are written in the same access, the new enable/irq_en values SHALL apply and the FIFO SHALL be empty afterwards.
REQ-028 No external writes to sticky flags other than clear SHALL exist; flags persist until clear or reset.

Reset
REQ-029 On resetn=0, immediately and without clk, SHALL set: iomem_ready=0, iomem_rdata=0, irq_out=0, FSM=IDLE, CTRL=0, THRESH=0, count=0, pointers=0, flags=0.
REQ-030 Reset asserted mid-access SHALL abort the access with no ready pulse; after release an access still held on iomem_valid SHALL be serviced as new.
REQ-031 FIFO storage contents SHALL NOT be reset.

Verification
REQ-032 Write CTRL=0x1, then write DATA 0xDEADBEEF then 0x12345678, read STATUS -> count=2, empty=0; read DATA twice -> 0xDEADBEEF then 0x12345678, with ready 1 cycle after valid each time.
REQ-033 Enable, then write DEPTH+1 words -> STATUS full=1, overflow=1, count=DEPTH; with irq_en=1 -> irq_out=1; write CTRL=0x7 -> count=0, overflow=0, irq_out=0.
REQ-034 Read DATA while empty -> rdata=0, underflow=1; then write DATA with enable=0 -> count stays 0.
REQ-035 THRESH=3, irq_en=1: after 2 pushes irq_out=0; after the 3rd push irq_out=1 one cycle after its ready; one pop -> irq_out=0.
REQ-036 Access at 0x0300_0100 or 0x0200_0000 -> iomem_ready stays 0 for 10 cycles; access at 0x0300_0040 -> ready, rdata=0.
REQ-037 Assert resetn=0 during ACK of a DATA read -> ready and rdata drop to 0 asynchronously; after release STATUS=empty, count=0.
